toggle_bus_synchronizer: RTL and testbench

Destination-side receiver for a multi-bit bus crossing into the `clk` domain using a toggle request/acknowledge protocol. The source holds `in_data` stable and flips `in_toggle`. This block runs the toggle through a parametrised STAGES-deep flop chain, then captures the bus. It presents the word on a valid/ready interface and returns `ack_toggle` to the source once the word is consumed. It generalises the per-bit double-flop synchronizer array to arbitrary depth, coherent wide capture and flow control.

---
 rtl/toggle_bus_sync_pkg.sv | 13 +
 rtl/toggle_bus_synchronizer_sync.sv | 40 ++++
 rtl/toggle_bus_synchronizer.sv | 131 +++++++++++++
 tb/tb_toggle_bus_synchronizer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_bus_sync_pkg.sv
// Shared types and constants for the toggle-handshake bus synchronizer.
package toggle_bus_sync_pkg;

  // Fewest flops allowed on the request toggle before it is considered settled.
  localparam int TOGGLE_BUS_SYNC_MIN_STAGES = 2;

  // Receiver FSM states: IDLE waits for a request, HOLD presents a captured word.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/toggle_bus_synchronizer_sync.sv
// Single-bit STAGES-deep synchronizer chain with a hold enable.
module n_flop_synchronizer
  import toggle_bus_sync_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic in,
  output logic out
);

  if (STAGES < TOGGLE_BUS_SYNC_MIN_STAGES) begin : g_bad_stages
    $error("n_flop_synchronizer: STAGES must be at least TOGGLE_BUS_SYNC_MIN_STAGES");
  end

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the asynchronous input one stage per enabled cycle.
  always_comb begin
    sync_d = sync_q;
    if (enable) begin
      sync_d = {sync_q[STAGES-2:0], in};
    end
  end

  // Chain register, cleared to 0 on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign out = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_bus_synchronizer.sv
// Destination-side receiver for a toggle request/acknowledge bus crossing.
// A flip of in_toggle is synchronized, edge-detected, and used to capture
// in_data once; the word is offered on out_valid/out_ready and ack_toggle
// flips when it is consumed.
// Optional feature: define TOGGLE_BUS_SYNC_OVERRUN_EN to add the sticky
// overrun flag and its overrun_clear input.
module toggle_bus_synchronizer
  import toggle_bus_sync_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_toggle,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef TOGGLE_BUS_SYNC_OVERRUN_EN
  output logic             overrun,
  input  logic             overrun_clear,
`endif
  output logic             ack_toggle
);

  if (STAGES < TOGGLE_BUS_SYNC_MIN_STAGES) begin : g_bad_stages
    $error("toggle_bus_synchronizer: STAGES must be at least TOGGLE_BUS_SYNC_MIN_STAGES");
  end

  logic             sync_out;
  logic             prev_q;
  logic             prev_d;
  logic             edge_det;
  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] out_data_d;
  logic             ack_q;
  logic             ack_d;

  n_flop_synchronizer #(
    .STAGES (STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .in     (in_toggle),
    .out    (sync_out)
  );

  // Any change of the settled toggle is one request.
  assign edge_det = (sync_out != prev_q);

  // Next-state logic: capture on request in IDLE, release on handshake in HOLD.
  always_comb begin
    prev_d     = prev_q;
    state_d    = state_q;
    out_data_d = out_data_q;
    ack_d      = ack_q;
    if (enable) begin
      prev_d = sync_out;
      case (state_q)
        IDLE: begin
          if (edge_det) begin
            out_data_d = in_data;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          // A request arriving here is dropped; out_data stays frozen.
          if (out_ready) begin
            state_d = IDLE;
            ack_d   = ~ack_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Edge register, FSM state, captured word and acknowledge toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= 1'b0;
      state_q    <= IDLE;
      out_data_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      state_q    <= state_d;
      out_data_q <= out_data_d;
      ack_q      <= ack_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = (state_q == HOLD);
  assign ack_toggle = ack_q;

`ifdef TOGGLE_BUS_SYNC_OVERRUN_EN
  logic overrun_q;
  logic overrun_d;

  // Sticky violation flag; a new violation outranks a simultaneous clear.
  always_comb begin
    overrun_d = overrun_q;
    if (enable) begin
      if (overrun_clear) begin
        overrun_d = 1'b0;
      end
      if ((state_q == HOLD) && edge_det) begin
        overrun_d = 1'b1;
      end
    end
  end

  // Overrun flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_toggle_bus_synchronizer.sv
// Self-checking bench for toggle_bus_synchronizer: a STAGES=2 and a STAGES=4
// instance share all inputs; each test resets both first.
module tb_toggle_bus_synchronizer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       in_toggle;
  logic [7:0] in_data;
  logic       out_ready;
  logic [7:0] od2, od4;
  logic       ov2, ov4;
  logic       ack2, ack4;
`ifdef TOGGLE_BUS_SYNC_OVERRUN_EN
  logic       overrun_clear;
  logic       orun2, orun4;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         wait_cyc;
    logic [7:0] exp_data;
    logic       exp_ack;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  toggle_bus_synchronizer #(.WIDTH(8), .STAGES(2)) dut2 (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .in_toggle     (in_toggle),
    .in_data       (in_data),
    .out_data      (od2),
    .out_valid     (ov2),
    .out_ready     (out_ready),
`ifdef TOGGLE_BUS_SYNC_OVERRUN_EN
    .overrun       (orun2),
    .overrun_clear (overrun_clear),
`endif
    .ack_toggle    (ack2)
  );

  toggle_bus_synchronizer #(.WIDTH(8), .STAGES(4)) dut4 (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .in_toggle     (in_toggle),
    .in_data       (in_data),
    .out_data      (od4),
    .out_valid     (ov4),
    .out_ready     (out_ready),
`ifdef TOGGLE_BUS_SYNC_OVERRUN_EN
    .overrun       (orun4),
    .overrun_clear (overrun_clear),
`endif
    .ack_toggle    (ack4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    enable    = 1'b1;
    in_toggle = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
`ifdef TOGGLE_BUS_SYNC_OVERRUN_EN
    overrun_clear = 1'b0;
`endif
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_valid2(input int limit, output int n);
    n = 0;
    while (!ov2 && n < limit) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    for (int i = 0; i < 16; i++) begin
      vecs[i].data     = 8'(i);
      vecs[i].wait_cyc = (i * 7) % 4;
      vecs[i].exp_data = 8'(i);
      vecs[i].exp_ack  = ((i + 1) % 2) == 1;
    end

    // Reset state
    do_reset();
    chk("rst_valid", ov2, 0);
    chk("rst_data", od2, 0);
    chk("rst_ack", ack2, 0);
    chk("rst_valid4", ov4, 0);
`ifdef TOGGLE_BUS_SYNC_OVERRUN_EN
    chk("rst_overrun", orun2, 0);
`endif

    // Single word, consumer always ready: STAGES+1 latency, one-cycle valid
    in_data   = 8'hA5;
    out_ready = 1'b1;
    in_toggle = ~in_toggle;
    step(2);
    chk("t1_valid_early", ov2, 0);
    step();
    chk("t1_valid", ov2, 1);
    chk("t1_data", od2, 8'hA5);
    chk("t1_ack_before", ack2, 0);
    step();
    chk("t1_valid_drop", ov2, 0);
    chk("t1_ack_after", ack2, 1);
    step();
    chk("t1_valid4", ov4, 1);
    chk("t1_data4", od4, 8'hA5);
    step();
    chk("t1_valid4_drop", ov4, 0);
    chk("t1_ack4", ack4, 1);

    // STAGES=4, consumer stalls 10 cycles
    do_reset();
    in_data   = 8'h3C;
    in_toggle = ~in_toggle;
    step(4);
    chk("t2_valid_early", ov4, 0);
    step();
    chk("t2_valid", ov4, 1);
    chk("t2_data", od4, 8'h3C);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!ov4 || od4 !== 8'h3C || ack4 !== 1'b0) bad++;
    end
    chk("t2_hold_stable", bad, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t2_valid_drop", ov4, 0);
    chk("t2_ack", ack4, 1);
    step(3);
    chk("t2_ack_stays", ack4, 1);

    // 16 back-to-back words, source waits for each ack
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_data   = vecs[i].data;
      in_toggle = ~in_toggle;
      wait_valid2(20, n);
      chk("t3_valid", ov2, 1);
      chk("t3_data", od2, vecs[i].exp_data);
      step(vecs[i].wait_cyc);
      chk("t3_held", ov2, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t3_ack", ack2, vecs[i].exp_ack);
      chk("t3_valid_drop", ov2, 0);
    end
`ifdef TOGGLE_BUS_SYNC_OVERRUN_EN
    chk("t3_no_overrun", orun2, 0);
`endif

    // Source violation: second request while the first word is pending
    do_reset();
    in_data   = 8'h11;
    in_toggle = ~in_toggle;
    wait_valid2(20, n);
    chk("t4_valid", ov2, 1);
    chk("t4_data", od2, 8'h11);
    in_data   = 8'h22;
    in_toggle = ~in_toggle;
    step(4);
    chk("t4_data_kept", od2, 8'h11);
    chk("t4_still_valid", ov2, 1);
`ifdef TOGGLE_BUS_SYNC_OVERRUN_EN
    chk("t4_overrun_set", orun2, 1);
    step(2);
    chk("t4_overrun_sticky", orun2, 1);
    overrun_clear = 1'b1;
    step();
    overrun_clear = 1'b0;
    chk("t4_overrun_clr", orun2, 0);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_valid_drop", ov2, 0);
    chk("t4_ack", ack2, 1);
    step(5);
    chk("t4_dropped_word", ov2, 0);

    // enable=0 mid-transfer stretches latency by 5, then freezes HOLD, then reset
    do_reset();
    in_data   = 8'h5A;
    in_toggle = ~in_toggle;
    step();
    enable = 1'b0;
    step(2);
    chk("t5_no_valid_normal", ov2, 0);
    step(3);
    enable = 1'b1;
    step();
    chk("t5_valid_early", ov2, 0);
    step();
    chk("t5_valid", ov2, 1);
    chk("t5_data", od2, 8'h5A);
    enable    = 1'b0;
    out_ready = 1'b1;
    in_data   = 8'hFF;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!ov2 || od2 !== 8'h5A || ack2 !== 1'b0) bad++;
    end
    chk("t5_frozen", bad, 0);
    enable    = 1'b1;
    out_ready = 1'b0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_valid", ov2, 0);
    chk("t5_rst_data", od2, 0);
    chk("t5_rst_ack", ack2, 0);

    // in_toggle held high through reset release gives exactly one transfer
    rst       = 1'b1;
    in_toggle = 1'b1;
    in_data   = 8'h77;
    out_ready = 1'b0;
    step(2);
    rst = 1'b0;
    step(2);
    chk("t6_valid_early", ov2, 0);
    step();
    chk("t6_valid", ov2, 1);
    chk("t6_data", od2, 8'h77);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t6_ack", ack2, 1);
    chk("t6_valid_drop", ov2, 0);
    step(6);
    chk("t6_single", ov2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
